// File: rtl/switch_debounce_pkg.sv
// switch_debounce_pkg: shared constants and helpers for the switch debouncer
package switch_debounce_pkg;
  localparam int DEFAULT_DEBOUNCE_LIMIT = 250000;
  localparam int SIM_DEBOUNCE_LIMIT = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;
  function automatic int cnt_width(input int limit);
    return $clog2(limit);
  endfunction
endpackage

// File: rtl/switch_debounce_if.sv
// switch_debounce_if: raw switch inputs and debounced outputs for NUM_SW channels
//   sw    raw asynchronous switch pins (driven by master)
//   level debounced level, press/rel one-cycle strobes, led LED drive (driven by slave)
interface switch_debounce_if #(parameter int NUM_SW = 4);
  logic [NUM_SW-1:0] sw;
  logic [NUM_SW-1:0] level;
  logic [NUM_SW-1:0] press;
  logic [NUM_SW-1:0] rel;
  logic [NUM_SW-1:0] led;
  modport master (output sw, input level, press, rel, led);
  modport slave (input sw, output level, press, rel, led);
endinterface

// File: rtl/switch_debounce_channel.sv
// debounce_channel: one switch channel - synchroniser, stability counter, level and strobes
//   clk, rst_n (async active-low), sw raw pin; level debounced, press/rel registered strobes
module debounce_channel import switch_debounce_pkg::*; #(
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic level,
  output logic press,
  output logic rel
);
  localparam int CW = cnt_width(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt;
  logic sync, done;
  assign sync = sync_q[SYNC_STAGES-1];
  // the synced level has differed for DEBOUNCE_LIMIT consecutive cycles
  assign done = (sync != level) && (cnt == LAST);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
      cnt <= (sync == level || done) ? '0 : cnt + 1'b1;
      level <= done ? sync : level;
      press <= done & sync;
      rel <= done & ~sync;
    end
  end
endmodule

// File: rtl/switch_debounce.sv
// switch_debounce: synchronise and debounce NUM_SW push-switches, drive LEDs
//   clk, rst_n (async active-low); bus (slave): sw in, level/press/rel/led out
//   SWITCH_DEBOUNCE_TOGGLE_EN defined: led toggles on each release strobe; else led = level
module switch_debounce import switch_debounce_pkg::*; #(
  parameter int NUM_SW = 4,
  parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input logic clk,
  input logic rst_n,
  switch_debounce_if.slave bus
);
  logic [NUM_SW-1:0] level, press, rel;
  if (DEBOUNCE_LIMIT < 2 || SYNC_STAGES < 2) begin : g_bad_param
    $error("switch_debounce: DEBOUNCE_LIMIT and SYNC_STAGES must both be >= 2");
  end
  for (genvar n = 0; n < NUM_SW; n++) begin : g_ch
    debounce_channel #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT), .SYNC_STAGES(SYNC_STAGES)) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .sw(bus.sw[n]),
      .level(level[n]),
      .press(press[n]),
      .rel(rel[n])
    );
  end
  assign bus.level = level;
  assign bus.press = press;
  assign bus.rel = rel;
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
  logic [NUM_SW-1:0] led_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= '0;
    else led_q <= led_q ^ rel;
  end
  assign bus.led = led_q;
`else
  assign bus.led = level;
`endif
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: randomized + directed stimulus, windowed reference model, queue scoreboard
module tb_switch_debounce;
  import switch_debounce_pkg::*;
  localparam int N = 4;
  localparam int L = SIM_DEBOUNCE_LIMIT;
  localparam int S = DEFAULT_SYNC_STAGES;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int fails = 0;
  switch_debounce_if #(.NUM_SW(N)) bus();
  switch_debounce #(.NUM_SW(N), .DEBOUNCE_LIMIT(L), .SYNC_STAGES(S)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] led;
  } exp_t;
  exp_t expq[$];

  // Reference model: a channel flips when every synced sample in the last L edges
  // differs from its level and at least L edges have passed since its last flip/reset.
  logic [N-1:0] rawq[$];
  logic [N-1:0] syncq[$];
  int since[N];
  logic [N-1:0] m_level, m_press, m_rel, m_led, m_s;
  logic m_flip;
  exp_t m_e;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rawq.delete();
      for (int k = 0; k < S; k++) rawq.push_back('0);
      syncq.delete();
      for (int c = 0; c < N; c++) since[c] = 0;
      m_level = '0;
      m_press = '0;
      m_rel = '0;
      m_led = '0;
      expq.delete();
    end else begin
      rawq.push_back(bus.sw);
      m_s = rawq[rawq.size() - 1 - S];
      if (rawq.size() > S + 1) void'(rawq.pop_front());
      syncq.push_back(m_s);
      if (syncq.size() > L) void'(syncq.pop_front());
`ifdef SWITCH_DEBOUNCE_TOGGLE_EN
      m_led = m_led ^ m_rel;
`endif
      for (int c = 0; c < N; c++) begin
        since[c]++;
        m_flip = (since[c] >= L) && (syncq.size() == L);
        for (int k = 0; k < syncq.size(); k++)
          if (syncq[k][c] == m_level[c]) m_flip = 1'b0;
        m_press[c] = m_flip && !m_level[c];
        m_rel[c] = m_flip && m_level[c];
        if (m_flip) begin
          m_level[c] = ~m_level[c];
          since[c] = 0;
        end
      end
`ifndef SWITCH_DEBOUNCE_TOGGLE_EN
      m_led = m_level;
`endif
      m_e.level = m_level;
      m_e.press = m_press;
      m_e.rel = m_rel;
      m_e.led = m_led;
      expq.push_back(m_e);
    end
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (!rst_n || expq.size() == 0) e = '0;
    else e = expq.pop_front();
    chk("level", bus.level, e.level);
    chk("press", bus.press, e.press);
    chk("release", bus.rel, e.rel);
    chk("led", bus.led, e.led);
    chk("press_and_release", bus.press & bus.rel, '0);
  end

  task automatic hold(input logic [N-1:0] v, input int n);
    bus.sw = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  logic [N-1:0] rv;
  int dur[N];
  initial begin
    bus.sw = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    // reset in the middle of a count, switch still held through release
    hold(4'b0001, 5);
    rst_n = 1'b0;
    hold(4'b0001, 2);
    rst_n = 1'b1;
    hold(4'b0001, 14);
    // clean press on channel 1
    hold(4'b0011, 14);
    // bouncing channel 2: 1,0,1,1,0 then held
    hold(4'b0111, 1);
    hold(4'b0011, 1);
    hold(4'b0111, 2);
    hold(4'b0011, 1);
    hold(4'b0111, 14);
    // glitch on channel 3 one cycle short of acceptance
    hold(4'b1111, 7);
    hold(4'b0111, 14);
    // all released, then simultaneous press and release
    hold(4'b0000, 14);
    hold(4'b1111, 14);
    hold(4'b0000, 14);
    // press/release channel 0 twice
    for (int i = 0; i < 2; i++) begin
      hold(4'b0001, 12);
      hold(4'b0000, 12);
    end
    // random hold durations straddling the limit, with occasional resets
    rv = '0;
    for (int c = 0; c < N; c++) dur[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        if (dur[c] == 0) begin
          rv[c] = ~rv[c];
          dur[c] = $urandom_range(1, 2 * L + 4);
        end
        dur[c]--;
      end
      rst_n = ($urandom_range(0, 499) != 0);
      hold(rv, 1);
    end
    rst_n = 1'b1;
    hold(4'b0000, 20);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
